// File: rtl/if_stage_pc_unit.sv
// Fetch stage of the pipelined RV32I core: the PC register, the instruction-memory
// address and the IF/ID pipeline register. Static predict-not-taken, one-bubble redirect.
module if_stage_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        id_branch_taken,
  input  logic [31:0] id_branch_target,
  input  logic        id_jump,
  input  logic [31:0] id_jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        flush,
  output logic        misalign_err,
  output logic [31:0] redirect_count,
  output logic [31:0] stall_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_pc4_q, if_id_pc4_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // A redirect is only trusted when ID holds a real instruction and its operands are current.
  assign redirect = !stall && if_id_valid_q && (id_jump || id_branch_taken);
  assign target   = id_jump ? id_jump_target : id_branch_target;
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d           = pc_q;
    if_id_pc_d     = if_id_pc_q;
    if_id_pc4_d    = if_id_pc4_q;
    if_id_instr_d  = if_id_instr_q;
    if_id_valid_d  = if_id_valid_q;
    misalign_d     = misalign_q;
    redirect_cnt_d = redirect_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    if (stall) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else if (redirect) begin
      pc_d           = {target[31:2], 2'b00};
      if_id_pc_d     = pc_q;
      if_id_pc4_d    = pc_plus4;
      if_id_instr_d  = NOP_INSTR;
      if_id_valid_d  = 1'b0;
      redirect_cnt_d = sat_inc(redirect_cnt_q);
      if (target[1:0] != 2'b00) misalign_d = 1'b1;
    end else begin
      pc_d          = pc_plus4;
      if_id_pc_d    = pc_q;
      if_id_pc4_d   = pc_plus4;
      if_id_instr_d = imem_rdata;
      if_id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      if_id_pc_q     <= RESET_PC;
      if_id_pc4_q    <= RESET_PC + 32'd4;
      if_id_instr_q  <= NOP_INSTR;
      if_id_valid_q  <= 1'b0;
      misalign_q     <= 1'b0;
      redirect_cnt_q <= 32'd0;
      stall_cnt_q    <= 32'd0;
    end else begin
      pc_q           <= pc_d;
      if_id_pc_q     <= if_id_pc_d;
      if_id_pc4_q    <= if_id_pc4_d;
      if_id_instr_q  <= if_id_instr_d;
      if_id_valid_q  <= if_id_valid_d;
      misalign_q     <= misalign_d;
      redirect_cnt_q <= redirect_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign imem_addr      = pc_q;
  assign if_id_pc       = if_id_pc_q;
  assign if_id_pc4      = if_id_pc4_q;
  assign if_id_instr    = if_id_instr_q;
  assign if_id_valid    = if_id_valid_q;
  assign flush          = redirect;
  assign misalign_err   = misalign_q;
  assign redirect_count = redirect_cnt_q;
  assign stall_count    = stall_cnt_q;

endmodule

// File: tb/tb_if_stage_pc_unit.sv
// Bench for if_stage_pc_unit: directed scenarios then random traffic, checked by a
// queue-based scoreboard fed from a cycle-level reference model of the fetch stage.
module tb_if_stage_pc_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        id_branch_taken = 1'b0;
  logic [31:0] id_branch_target = 32'd0;
  logic        id_jump = 1'b0;
  logic [31:0] id_jump_target = 32'd0;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] if_id_pc, if_id_pc4, if_id_instr;
  logic        if_id_valid, flush, misalign_err;
  logic [31:0] redirect_count, stall_count;

  if_stage_pc_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .id_branch_taken(id_branch_taken), .id_branch_target(id_branch_target),
    .id_jump(id_jump), .id_jump_target(id_jump_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4), .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid), .flush(flush), .misalign_err(misalign_err),
    .redirect_count(redirect_count), .stall_count(stall_count)
  );

  // Instruction memory: low words are 0x11,0x22,0x33,0x44; elsewhere an address hash.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'h10) mem_word = ({30'b0, a[3:2]} + 32'd1) * 32'h11;
    else            mem_word = {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction
  assign imem_rdata = mem_word(imem_addr);

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] addr, pc, pc4, instr, rc, sc;
    logic        valid, flush, mis;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);
  logic [EXP_W-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: every cycle with an expectation pending, compare all visible outputs.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check32("imem_addr", imem_addr, e.addr);
      check32("if_id_pc", if_id_pc, e.pc);
      check32("if_id_pc4", if_id_pc4, e.pc4);
      check32("if_id_instr", if_id_instr, e.instr);
      check32("if_id_valid", {31'b0, if_id_valid}, {31'b0, e.valid});
      check32("flush", {31'b0, flush}, {31'b0, e.flush});
      check32("misalign_err", {31'b0, misalign_err}, {31'b0, e.mis});
      check32("redirect_count", redirect_count, e.rc);
      check32("stall_count", stall_count, e.sc);
    end
  end

  // ---------------- reference model ----------------
  logic        m_known = 1'b0;
  logic [31:0] m_pc, m_ifpc, m_ifpc4, m_instr, m_rc, m_sc;
  logic        m_valid, m_mis;

  // Advance the architectural view by one clock, using the inputs applied during that cycle.
  task automatic model_edge();
    logic [31:0] tgt;
    if (rst) begin
      m_known = 1'b1;
      m_pc = RESET_PC; m_ifpc = RESET_PC; m_ifpc4 = RESET_PC + 32'd4;
      m_instr = NOP_INSTR; m_valid = 1'b0; m_mis = 1'b0; m_rc = 0; m_sc = 0;
    end else if (m_known) begin
      if (stall) begin
        if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      end else if (m_valid && (id_jump || id_branch_taken)) begin
        tgt = id_jump ? id_jump_target : id_branch_target;
        m_ifpc = m_pc; m_ifpc4 = m_pc + 4;
        m_instr = NOP_INSTR; m_valid = 1'b0;
        m_pc = tgt & 32'hFFFF_FFFC;
        if (tgt % 4 != 0) m_mis = 1'b1;
        if (m_rc != 32'hFFFF_FFFF) m_rc = m_rc + 1;
      end else begin
        m_instr = mem_word(m_pc); m_ifpc = m_pc; m_ifpc4 = m_pc + 4;
        m_valid = 1'b1; m_pc = m_pc + 4;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic s, input logic bt, input logic [31:0] btg,
                       input logic j, input logic [31:0] jtg);
    exp_t e;
    @(posedge clk);
    #1;
    model_edge();
    rst = r; stall = s;
    id_branch_taken = bt; id_branch_target = btg;
    id_jump = j; id_jump_target = jtg;
    if (m_known) begin
      e.addr = m_pc; e.pc = m_ifpc; e.pc4 = m_ifpc4; e.instr = m_instr;
      e.rc = m_rc; e.sc = m_sc; e.valid = m_valid; e.mis = m_mis;
      e.flush = !s && m_valid && (j || bt);
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(); drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0); endtask

  function automatic logic [31:0] pick_target();
    int unsigned mode;
    logic [31:0] t;
    mode = $urandom_range(0, 7);
    t = $urandom;
    if (mode == 0)      pick_target = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFC : 32'hFFFF_FFF8;
    else if (mode == 1) pick_target = t;
    else                pick_target = {t[31:2], 2'b00};
  endfunction

  initial begin
    // Reset, then free-run through 0,4,8,C.
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    idle();
    idle(); idle(); idle();
    // PC=0x10 with a valid instruction in ID: taken branch to 0x40.
    drive(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'd0);
    idle(); idle(); idle();
    // Jump held during a three-cycle stall, then taken once the stall drops.
    repeat (3) drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h80);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h80);
    idle(); idle();
    // Jump and branch together: the jump wins.
    drive(1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 32'h100);
    // Redirect while ID holds a bubble must be ignored.
    drive(1'b0, 1'b0, 1'b1, 32'h400, 1'b1, 32'h500);
    idle();
    // Misaligned jump target.
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h102);
    idle(); idle();
    // PC wrap from the top of the address space.
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC);
    idle(); idle(); idle();
    // Reset asserted in a redirect cycle.
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h300);
    idle(); idle(); idle();
    // Reset asserted mid-stall.
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    idle(); idle();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0, pick_target(),
            $urandom_range(0, 7) == 0, pick_target());
    end
    idle();

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
